// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multi-cycle control unit: ULA selects, opcodes, FSM states
// and the bundled datapath control word.
package controle_multiciclo_pkg;

  localparam logic [2:0] ULA_ADD = 3'd0;
  localparam logic [2:0] ULA_SUB = 3'd1;
  localparam logic [2:0] ULA_SLL = 3'd2;
  localparam logic [2:0] ULA_SRL = 3'd3;
  localparam logic [2:0] ULA_SLT = 3'd4;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] PC_SRC_ULA    = 2'b00;
  localparam logic [1:0] PC_SRC_ULAOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG = 2'b00;
  localparam logic [1:0] SRC_B_ONE = 2'b01;
  localparam logic [1:0] SRC_B_IMM = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_ALU   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd12,
    ST_ERROR    = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [2:0] ctrl_ula;
    logic       halted;
    logic       error;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op[3] == 1'b0) && (op[2:0] <= OP_SLT[2:0]);
  endfunction

endpackage

// File: rtl/controle_multiciclo_espera.sv
// Memory-wait cycle counter: clear has priority over increment; terminal flags count == LIMITE.
// Single-cycle registered count, terminal is combinational from the register.
module contador_espera #(
  parameter int unsigned LIMITE = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic terminal
);

  localparam logic [7:0] LIMITE_8 = LIMITE[7:0];

  logic [7:0] contagem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem <= 8'd0;
    end else if (clr) begin
      contagem <= 8'd0;
    end else if (inc) begin
      contagem <= contagem + 8'd1;
    end
  end

  assign terminal = (contagem == LIMITE_8);

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle control FSM for the 8-bit core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// Moore strobes plus mem_ready-qualified completions, timeout trap to ERROR.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       ula_src_a,
  output logic [1:0] ula_src_b,
  output logic [2:0] ctrl_ula,
  output logic       halted,
  output logic       error
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   esperando;
  logic   timeout;

  // The branch decision is made in the datapath by gating pc_write_cond with zero.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign esperando = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

  contador_espera #(
    .LIMITE (MEM_TIMEOUT)
  ) u_espera (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_nxt != state),
    .inc      (esperando && !mem_ready),
    .terminal (timeout)
  );

  always_comb begin
    state_nxt     = state;
    ctrl          = '0;
    ctrl.ctrl_ula = ULA_ADD;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ula_src_b = SRC_B_ONE;
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PC_SRC_ULA;
          state_nxt      = ST_DECODE;
        end else if (timeout) begin
          state_nxt = ST_ERROR;
        end
      end

      ST_DECODE: begin
        ctrl.ula_src_b = SRC_B_IMM;
        if (is_rtype(opcode)) begin
          state_nxt = ST_EXEC_R;
        end else begin
          case (opcode)
            OP_ADDI:      state_nxt = ST_EXEC_I;
            OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
            OP_BEQ:       state_nxt = ST_BRANCH;
            OP_J:         state_nxt = ST_JUMP;
            OP_HALT:      state_nxt = ST_HALT;
            default:      state_nxt = ST_ERROR;
          endcase
        end
      end

      ST_EXEC_R: begin
        ctrl.ula_src_a = 1'b1;
        ctrl.ula_src_b = SRC_B_REG;
        ctrl.ctrl_ula  = opcode[2:0];
        state_nxt      = ST_WB_ALU;
      end

      ST_EXEC_I: begin
        ctrl.ula_src_a = 1'b1;
        ctrl.ula_src_b = SRC_B_IMM;
        state_nxt      = ST_WB_ALU;
      end

      ST_WB_ALU: begin
        ctrl.reg_write = 1'b1;
        state_nxt      = ST_FETCH;
      end

      ST_MEM_ADDR: begin
        ctrl.ula_src_a = 1'b1;
        ctrl.ula_src_b = SRC_B_IMM;
        state_nxt      = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end

      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) begin
          state_nxt = ST_WB_MEM;
        end else if (timeout) begin
          state_nxt = ST_ERROR;
        end
      end

      ST_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_nxt       = ST_FETCH;
      end

      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready) begin
          state_nxt = ST_FETCH;
        end else if (timeout) begin
          state_nxt = ST_ERROR;
        end
      end

      ST_BRANCH: begin
        ctrl.ula_src_a     = 1'b1;
        ctrl.ula_src_b     = SRC_B_REG;
        ctrl.ctrl_ula      = ULA_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ULAOUT;
        state_nxt          = ST_FETCH;
      end

      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
        state_nxt      = ST_FETCH;
      end

      ST_HALT: begin
        ctrl.halted = 1'b1;
      end

      ST_ERROR: begin
        ctrl.error = 1'b1;
      end

      // Unreachable encodings trap rather than wander.
      default: begin
        state_nxt = ST_ERROR;
      end
    endcase
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign ir_write      = ctrl.ir_write;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign ula_src_a     = ctrl.ula_src_a;
  assign ula_src_b     = ctrl.ula_src_b;
  assign ctrl_ula      = ctrl.ctrl_ula;
  assign halted        = ctrl.halted;
  assign error         = ctrl.error;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: every cycle's full control word is compared
// against a hand-built expected vector.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       reg_write, mem_to_reg, ula_src_a, halted, error;
  logic [1:0] pc_source, ula_src_b;
  logic [2:0] ctrl_ula;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  controle_multiciclo #(
    .MEM_TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .ula_src_a     (ula_src_a),
    .ula_src_b     (ula_src_b),
    .ctrl_ula      (ctrl_ula),
    .halted        (halted),
    .error         (error)
  );

  logic [17:0] obs;
  assign obs = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
                reg_write, mem_to_reg, ula_src_a, ula_src_b, ctrl_ula, halted, error};

  function automatic logic [17:0] mk(input logic pcw, input logic pcc, input logic [1:0] pcs,
                                     input logic irw, input logic iod, input logic mr,
                                     input logic mw, input logic rw, input logic m2r,
                                     input logic sa, input logic [1:0] sb, input logic [2:0] cu,
                                     input logic h, input logic e);
    return {pcw, pcc, pcs, irw, iod, mr, mw, rw, m2r, sa, sb, cu, h, e};
  endfunction

  //                               pcw pcc pcs    irw iod mr mw rw m2r sa sb     cu    h  e
  localparam logic [17:0] E_IDLE  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 0, 0);
  localparam logic [17:0] E_FWAIT = mk(0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'd0, 0, 0);
  localparam logic [17:0] E_FDONE = mk(1, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'd0, 0, 0);
  localparam logic [17:0] E_DEC   = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 3'd0, 0, 0);
  localparam logic [17:0] E_R_ADD = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'd0, 0, 0);
  localparam logic [17:0] E_R_SUB = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'd1, 0, 0);
  localparam logic [17:0] E_R_SLT = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'd4, 0, 0);
  localparam logic [17:0] E_IMM   = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'd0, 0, 0);
  localparam logic [17:0] E_WBALU = mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'd0, 0, 0);
  localparam logic [17:0] E_MRD   = mk(0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'd0, 0, 0);
  localparam logic [17:0] E_WBMEM = mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'd0, 0, 0);
  localparam logic [17:0] E_MWR   = mk(0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b00, 3'd0, 0, 0);
  localparam logic [17:0] E_BR    = mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'd1, 0, 0);
  localparam logic [17:0] E_JMP   = mk(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 0, 0);
  localparam logic [17:0] E_HALT  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 1, 0);
  localparam logic [17:0] E_ERR   = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 0, 1);

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive mem_ready mid-low-phase, then check the control word.
  task automatic cyc(input string tag, input logic mr, input logic [17:0] exp);
    @(negedge clk);
    mem_ready = mr;
    #1;
    check_eq(tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check_eq("reset_idle", obs, E_IDLE);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 4'b0000;
    zero      = 1'b0;
    mem_ready = 1'b0;

    do_reset();

    opcode = 4'b0000;
    cyc("add_fetch", 1, E_FDONE);
    cyc("add_decode", 1, E_DEC);
    cyc("add_exec", 1, E_R_ADD);
    cyc("add_wb", 1, E_WBALU);

    opcode = 4'b0100;
    cyc("slt_fetch", 1, E_FDONE);
    cyc("slt_decode", 1, E_DEC);
    cyc("slt_exec", 1, E_R_SLT);
    cyc("slt_wb", 1, E_WBALU);

    opcode = 4'b0001;
    cyc("sub_fetch", 1, E_FDONE);
    cyc("sub_decode", 0, E_DEC);
    cyc("sub_exec", 0, E_R_SUB);
    cyc("sub_wb", 1, E_WBALU);

    opcode = 4'b0101;
    cyc("addi_fetch", 1, E_FDONE);
    cyc("addi_decode", 1, E_DEC);
    cyc("addi_exec", 1, E_IMM);
    cyc("addi_wb", 1, E_WBALU);

    opcode = 4'b0110;
    cyc("lw_fetch", 1, E_FDONE);
    cyc("lw_decode", 1, E_DEC);
    cyc("lw_addr", 1, E_IMM);
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 0, E_MRD);
    cyc("lw_rd_done", 1, E_MRD);
    cyc("lw_wb", 1, E_WBMEM);

    opcode = 4'b0111;
    cyc("sw_fetch", 1, E_FDONE);
    cyc("sw_decode", 1, E_DEC);
    cyc("sw_addr", 1, E_IMM);
    cyc("sw_wr", 1, E_MWR);

    opcode = 4'b1000;
    zero   = 1'b1;
    cyc("beq_fetch", 1, E_FDONE);
    cyc("beq_decode", 1, E_DEC);
    cyc("beq_branch", 1, E_BR);

    opcode = 4'b1001;
    zero   = 1'b0;
    cyc("j_fetch", 1, E_FDONE);
    cyc("j_decode", 1, E_DEC);
    cyc("j_jump", 1, E_JMP);

    // Fetch stalls 15 cycles, ready arrives on the 16th, exactly at the timeout boundary.
    opcode = 4'b1111;
    for (int i = 0; i < 15; i++) cyc("fetch_stall", 0, E_FWAIT);
    cyc("fetch_ready_at_limit", 1, E_FDONE);
    cyc("halt_decode", 1, E_DEC);
    cyc("halt_state", 0, E_HALT);
    cyc("halt_stays_a", 1, E_HALT);
    cyc("halt_stays_b", 0, E_HALT);

    do_reset();
    for (int i = 0; i < 16; i++) cyc("fetch_timeout_wait", 0, E_FWAIT);
    cyc("timeout_error", 0, E_ERR);
    cyc("error_stays", 1, E_ERR);

    do_reset();
    opcode = 4'b1010;
    cyc("illegal_fetch", 1, E_FDONE);
    cyc("illegal_decode", 1, E_DEC);
    cyc("illegal_error", 1, E_ERR);

    do_reset();
    opcode = 4'b0111;
    cyc("sw2_fetch", 1, E_FDONE);
    cyc("sw2_decode", 1, E_DEC);
    cyc("sw2_addr", 1, E_IMM);
    cyc("sw2_wr_wait", 0, E_MWR);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_drop", obs, E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("idle_after_release", obs, E_IDLE);
    cyc("fetch_after_release", 0, E_FWAIT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multi-cycle control unit of the 8-bit processor; sits directly upstream of the ULA and drives its `ctrl_ula` select plus all datapath strobes.
- Consumes the instruction-register opcode, the ULA `zero` flag and a memory-ready handshake.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, with a memory-wait timeout that traps to an error state.

Parameters:
- MEM_TIMEOUT, 15, maximum consecutive cycles waiting on `mem_ready` before trapping; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  4  instr[7:4] from the instruction register
- zero  in  1  ULA zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if `zero`; datapath ANDs it with `zero`
- pc_source  out  2  PC mux: 00 ULA result, 01 ULAOut register, 10 jump target
- ir_write  out  1  load instruction register
- i_or_d  out  1  memory address: 0 PC, 1 ULAOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write
- mem_to_reg  out  1  write-back data: 0 ULAOut, 1 MDR
- ula_src_a  out  1  ULA inA: 0 PC, 1 register A
- ula_src_b  out  2  ULA inB: 00 register B, 01 constant 1, 10 sign-extended immediate
- ctrl_ula  out  3  ULA operation select
- halted  out  1  core stopped by HALT
- error  out  1  illegal opcode or memory timeout

Behaviour:
- One clock; reset is asynchronous and active-low.
- State register and wait counter reset asynchronously.
- Reset state is IDLE. All outputs are 0 in IDLE; `ctrl_ula` is ULA_ADD.
- IDLE → FETCH unconditionally on the first clock after `rst_n` rises.
- All outputs are Moore-decoded from state, except the FETCH/MEM_RD/MEM_WR completion strobes, which also depend on `mem_ready`.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SRL, 0100 SLT
  - 0101 ADDI, 0110 LW, 0111 SW, 1000 BEQ, 1001 J
  - 1111 HALT; all others illegal.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, ula_src_a=0, ula_src_b=01, ctrl_ula=ADD.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_source=00, next state DECODE.
  - Otherwise stay in FETCH with no write strobes.
- DECODE: ula_src_a=0, ula_src_b=10, ctrl_ula=ADD (branch target into ULAOut). Next state by opcode:
  - R-type → EXEC_R
  - ADDI → EXEC_I
  - LW/SW → MEM_ADDR
  - BEQ → BRANCH
  - J → JUMP
  - HALT → HALT
  - other → ERROR
- EXEC_R: ula_src_a=1, ula_src_b=00, ctrl_ula from opcode[2:0] (000 ADD … 100 SLT) → WB_ALU.
- EXEC_I: ula_src_a=1, ula_src_b=10, ctrl_ula=ADD → WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0 → FETCH.
- MEM_ADDR: ula_src_a=1, ula_src_b=10, ctrl_ula=ADD. Next state MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, i_or_d=1; on mem_ready → WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1 → FETCH.
- MEM_WR: mem_write=1, i_or_d=1; on mem_ready → FETCH.
- BRANCH: ula_src_a=1, ula_src_b=00, ctrl_ula=SUB, pc_write_cond=1, pc_source=01 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.
- Latencies:
  - R-type/ADDI: 4 cycles.
  - LW: 5 cycles; SW: 4 cycles.
  - BEQ/J: 3 cycles.
  - Each memory state adds one cycle per mem_ready=0 cycle.
- Wait counter: 8-bit.
  - Increments each cycle spent in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Clears on any state change.
  - When it equals MEM_TIMEOUT with mem_ready still 0, next state is ERROR.
  - mem_ready=1 in that same cycle wins: normal completion, no error.
- HALT: halted=1, all strobes 0; absorbing until reset.
- ERROR: error=1, all strobes 0; absorbing until reset.
- mem_read and mem_write are never both 1.
- reg_write, pc_write and mem_write are never asserted in IDLE, HALT or ERROR.
- Reset mid-instruction: immediate return to IDLE; any in-flight memory request drops the same instant.

Decomposition:
- `define.v` (shared):
  - ULA_ADD=3'd0, ULA_SUB=3'd1, ULA_SLL=3'd2, ULA_SRL=3'd3, ULA_SLT=3'd4
  - 4-bit opcode constants
  - state encodings
- Sub-module `contador_espera` (wait counter with clear, increment and terminal-count compare); the FSM stays in the top module.

Test Plan:
- Reset, then ADD (0000), mem_ready always 1 → IDLE, FETCH, DECODE, EXEC_R, WB_ALU. ctrl_ula=000 in EXEC_R; reg_write=1 only in WB_ALU; next FETCH on cycle 5.
- SLT (0100) → ctrl_ula=100 in EXEC_R. SUB (0001) → 001. All strobes 0 during DECODE apart from selects.
- LW with mem_ready low 3 cycles in MEM_RD → mem_read=1 and i_or_d=1 held 4 cycles; WB_MEM asserts reg_write=1, mem_to_reg=1; no error.
- FETCH with mem_ready stuck 0, MEM_TIMEOUT=15 → ERROR after 16 FETCH cycles, error=1, mem_read=0. Repeat with mem_ready=1 on cycle 16 → DECODE, no error.
- BEQ (1000) → BRANCH has ctrl_ula=001, pc_write_cond=1, pc_source=01. J (1001) → pc_write=1, pc_source=10. Opcode 1010 → ERROR after DECODE.
- HALT (1111) → halted=1 and stays. rst_n pulsed low mid-MEM_WR → mem_write drops asynchronously; IDLE, then FETCH one cycle after release.
